// File: rtl/tsi_command_fsm.sv
// Host command FSM: parses cmd/addr/len words from a 32-bit host stream and runs word-wise memory reads/writes.
// Define TSI_CMD_ERR_EN to add a sticky illegal-command flag on output err.
module tsi_command_fsm #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              busy
`ifdef TSI_CMD_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [3:0] {
    S_CMD     = 4'd0,
    S_ADDR_LO = 4'd1,
    S_ADDR_HI = 4'd2,
    S_LEN_LO  = 4'd3,
    S_LEN_HI  = 4'd4,
    S_WR_DATA = 4'd5,
    S_WR_REQ  = 4'd6,
    S_WR_ACK  = 4'd7,
    S_RD_REQ  = 4'd8,
    S_RD_RESP = 4'd9,
    S_RD_OUT  = 4'd10
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              mem_req_valid_q;
  logic              busy_q;
  logic              cmd_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic accept;
  logic cmd_legal;
  logic word_done;
  logic last_word;

  assign accept    = in_valid & in_ready_q;
  assign cmd_legal = (in_bits[31:1] == 31'd0);
  assign last_word = (cnt_q == '0);
  // A word completes on the write ack or when the host takes the read word.
  assign word_done = ((state_q == S_WR_ACK) & mem_resp_valid) |
                     ((state_q == S_RD_OUT) & out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:     if (accept && cmd_legal) state_d = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_d = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO:  if (accept) state_d = S_LEN_HI;
      S_LEN_HI:  if (accept) state_d = cmd_write_q ? S_WR_DATA : S_RD_REQ;
      S_WR_DATA: if (accept) state_d = S_WR_REQ;
      S_WR_REQ:  if (mem_req_ready) state_d = S_WR_ACK;
      S_WR_ACK:  if (mem_resp_valid) state_d = last_word ? S_CMD : S_WR_DATA;
      S_RD_REQ:  if (mem_req_ready) state_d = S_RD_RESP;
      S_RD_RESP: if (mem_resp_valid) state_d = S_RD_OUT;
      S_RD_OUT:  if (out_ready) state_d = last_word ? S_CMD : S_RD_REQ;
      default:   state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_CMD;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      cmd_write_q     <= 1'b0;
      addr_q          <= '0;
      cnt_q           <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      // Handshake flags are decoded from the next state so they line up with it.
      in_ready_q      <= state_d inside {S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_WR_DATA};
      out_valid_q     <= (state_d == S_RD_OUT);
      mem_req_valid_q <= state_d inside {S_WR_REQ, S_RD_REQ};
      busy_q          <= (state_d != S_CMD);

      case (state_q)
        S_CMD:     if (accept && cmd_legal) cmd_write_q <= in_bits[0];
        S_ADDR_LO: if (accept) addr_q <= ADDR_W'(in_bits);
        S_ADDR_HI: if (accept) addr_q <= ADDR_W'({in_bits, 32'(addr_q)});
        S_LEN_LO:  if (accept) cnt_q <= LEN_W'(in_bits);
        S_LEN_HI:  if (accept) cnt_q <= LEN_W'({in_bits, 32'(cnt_q)});
        S_WR_DATA: if (accept) wdata_q <= in_bits;
        S_RD_RESP: if (mem_resp_valid) rdata_q <= mem_resp_data;
        default:   ;
      endcase

      // Address wraps naturally modulo 2^ADDR_W.
      if (word_done) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (!last_word) cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

`ifdef TSI_CMD_ERR_EN
  logic err_q;

  // Sticky: only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state_q == S_CMD) && accept && !cmd_legal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_bits      = rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = cmd_write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tsi_command_fsm.sv
// Bench for tsi_command_fsm: transaction-level model checked every cycle plus directed literal checks.
// Compile with TSI_CMD_ERR_EN defined to also cover the err port.
module tb_tsi_command_fsm;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bits;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;
`ifdef TSI_CMD_ERR_EN
  logic        err;
`endif

  tsi_command_fsm dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bits        (in_bits),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_bits       (out_bits),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy)
`ifdef TSI_CMD_ERR_EN
    ,
    .err            (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Transaction model state
  bit          m_busy, m_is_wr, m_need_data, m_need_req, m_outstanding, m_have_out, m_err;
  int          m_hdr;
  logic [63:0] m_addr, m_len;
  logic [31:0] m_wdata, m_out_word;
  longint      m_left;
  bit          primed;
  bit          exp_rdy;
  int          stall_cycles;
  int          n_req_fires;
  int          out_stall;

  logic [63:0] log_addr[$];
  logic [31:0] log_data[$];
  bit          log_wr[$];
  logic [31:0] log_out[$];
  logic [31:0] rd_q[$];

  // Per-cycle compare, then advance the model by what the coming edge will do.
  initial begin
    bit acc, fire, resp, ofire;
    primed = 0;
    forever begin
      @(negedge clock);
      exp_rdy = !m_busy || (m_hdr < 4) || m_need_data;
      if (primed) begin
        chk("busy", busy, m_busy);
        chk("in_ready", in_ready, exp_rdy);
        chk("mem_req_valid", mem_req_valid, m_need_req);
        if (m_need_req) begin
          chk("mem_req_addr", mem_req_addr, m_addr);
          chk("mem_req_write", mem_req_write, m_is_wr);
          if (m_is_wr) chk("mem_req_data", mem_req_data, m_wdata);
        end
        chk("out_valid", out_valid, m_have_out);
        if (m_have_out) chk("out_bits", out_bits, m_out_word);
`ifdef TSI_CMD_ERR_EN
        chk("err", err, m_err);
`endif
      end
      if (!reset && mem_req_valid && mem_req_ready) begin
        log_addr.push_back(mem_req_addr);
        log_data.push_back(mem_req_data);
        log_wr.push_back(mem_req_write);
      end
      if (!reset && out_valid && out_ready) log_out.push_back(out_bits);
      if (!reset && out_valid && !out_ready) stall_cycles++;

      if (reset) begin
        m_busy = 0; m_need_data = 0; m_need_req = 0; m_outstanding = 0;
        m_have_out = 0; m_err = 0; m_hdr = 4; m_is_wr = 0;
        m_addr = '0; m_len = '0; m_wdata = '0; m_out_word = '0; m_left = 0;
      end else begin
        acc   = in_valid && exp_rdy;
        fire  = m_need_req && mem_req_ready;
        resp  = mem_resp_valid && m_outstanding;
        ofire = m_have_out && out_ready;
        if (acc) begin
          if (!m_busy) begin
            if (in_bits <= 32'd1) begin
              m_busy = 1; m_is_wr = in_bits[0]; m_hdr = 0;
            end else begin
              m_err = 1;
            end
          end else if (m_hdr < 4) begin
            case (m_hdr)
              0: m_addr[31:0]  = in_bits;
              1: m_addr[63:32] = in_bits;
              2: m_len[31:0]   = in_bits;
              default: m_len[63:32] = in_bits;
            endcase
            m_hdr++;
            if (m_hdr == 4) begin
              m_left = longint'(m_len[31:0]) + 1;
              if (m_is_wr) m_need_data = 1;
              else m_need_req = 1;
            end
          end else begin
            m_wdata = in_bits; m_need_data = 0; m_need_req = 1;
          end
        end
        if (fire) begin
          m_need_req = 0; m_outstanding = 1; n_req_fires++;
        end
        if (resp) begin
          m_outstanding = 0;
          if (m_is_wr) begin
            m_addr = m_addr + 64'd4; m_left--;
            if (m_left == 0) m_busy = 0;
            else m_need_data = 1;
          end else begin
            m_have_out = 1; m_out_word = mem_resp_data;
          end
        end
        if (ofire) begin
          m_have_out = 0; m_addr = m_addr + 64'd4; m_left--;
          if (m_left == 0) m_busy = 0;
          else m_need_req = 1;
        end
      end
      primed = 1;
    end
  end

  // Memory responder: one completion pulse the cycle after each accepted request.
  initial begin
    bit rw;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clock);
      if (!reset && mem_req_valid && mem_req_ready) begin
        rw = mem_req_write;
        @(posedge clock); #1;
        mem_resp_valid = 1'b1;
        if (rw || rd_q.size() == 0) mem_resp_data = 32'hBAD0BAD0;
        else mem_resp_data = rd_q.pop_front();
        @(posedge clock); #1;
        mem_resp_valid = 1'b0;
      end
    end
  end

  // Host output side: hold off out_ready for out_stall cycles of each out_valid.
  initial begin
    int ow;
    ow = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!out_valid) begin
        out_ready = 1'b0; ow = 0;
      end else begin
        out_ready = (ow >= out_stall); ow++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_bits  = w;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        timeout_fail("send");
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] cmd, input logic [63:0] addr, input logic [63:0] len);
    send(cmd);
    send(addr[31:0]);
    send(addr[63:32]);
    send(len[31:0]);
    send(len[63:32]);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while ((busy || m_busy) && t < 500);
    if (t >= 500) timeout_fail(name);
    @(posedge clock); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_wr.delete(); log_out.delete();
  endtask

  task automatic chk_req(input string name, input int i, input logic [63:0] a,
                         input logic [31:0] d, input bit wr);
    chk({name, "_addr"}, log_addr[i], a);
    if (wr) chk({name, "_data"}, log_data[i], 64'(d));
    chk({name, "_write"}, 64'(log_wr[i]), 64'(wr));
  endtask

  initial begin
    logic [63:0] a0;
    logic [31:0] d0;
    int fires0, t;
    reset = 1'b1; in_valid = 1'b0; in_bits = '0; mem_req_ready = 1'b1; out_stall = 0;
    stall_cycles = 0; n_req_fires = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_data", mem_req_data, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_mem_req_write", mem_req_write, 0);
    @(posedge clock); #1;

    // Two-word write
    clear_logs();
    send_hdr(32'd1, 64'h8000_0000, 64'd1);
    send(32'hA);
    send(32'hB);
    wait_idle("wr2_idle");
    chk("wr2_nreq", 64'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      chk_req("wr2_0", 0, 64'h8000_0000, 32'hA, 1'b1);
      chk_req("wr2_1", 1, 64'h8000_0004, 32'hB, 1'b1);
    end
    chk("wr2_busy_low", busy, 0);

    // Three-word read with host back-pressure
    clear_logs();
    rd_q.push_back(32'h11); rd_q.push_back(32'h22); rd_q.push_back(32'h33);
    out_stall = 3; stall_cycles = 0;
    send_hdr(32'd0, 64'h1000, 64'd2);
    wait_idle("rd3_idle");
    out_stall = 0;
    chk("rd3_nout", 64'(log_out.size()), 3);
    if (log_out.size() == 3) begin
      chk("rd3_out0", 64'(log_out[0]), 64'h11);
      chk("rd3_out1", 64'(log_out[1]), 64'h22);
      chk("rd3_out2", 64'(log_out[2]), 64'h33);
    end
    chk("rd3_nreq", 64'(log_addr.size()), 3);
    if (log_addr.size() == 3) chk_req("rd3_2", 2, 64'h1008, 32'h0, 1'b0);
    chk("rd3_stall_cycles", 64'(stall_cycles), 9);

    // Memory back-pressure on a write request
    clear_logs();
    mem_req_ready = 1'b0;
    fires0 = n_req_fires;
    send_hdr(32'd1, 64'h2000, 64'd0);
    send(32'h55);
    a0 = mem_req_addr; d0 = mem_req_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_valid", mem_req_valid, 1);
      chk("bp_addr", mem_req_addr, 64'h2000);
      chk("bp_data_stable", 64'(mem_req_data), 64'(d0));
      chk("bp_addr_stable", mem_req_addr, a0);
    end
    @(posedge clock); #1;
    mem_req_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_fires", 64'(n_req_fires - fires0), 1);
    if (log_addr.size() == 1) chk_req("bp_req", 0, 64'h2000, 32'h55, 1'b1);

    // Address wrap at the top of the 64-bit space
    clear_logs();
    rd_q.push_back(32'hDEAD0001); rd_q.push_back(32'hDEAD0002);
    send_hdr(32'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
    wait_idle("wrap_idle");
    chk("wrap_nreq", 64'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      chk_req("wrap_0", 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b0);
      chk_req("wrap_1", 1, 64'h0, 32'h0, 1'b0);
    end
    if (log_out.size() == 2) chk("wrap_out1", 64'(log_out[1]), 64'hDEAD0002);

    // Illegal command word is dropped, then a normal write
    clear_logs();
    send(32'd7);
    @(negedge clock);
    chk("ill_busy", busy, 0);
    chk("ill_in_ready", in_ready, 1);
`ifdef TSI_CMD_ERR_EN
    chk("ill_err", err, 1);
`endif
    @(posedge clock); #1;
    send_hdr(32'd1, 64'h3000, 64'd0);
    send(32'h77);
    wait_idle("ill_idle");
    chk("ill_nreq", 64'(log_addr.size()), 1);
    if (log_addr.size() == 1) chk_req("ill_req", 0, 64'h3000, 32'h77, 1'b1);
`ifdef TSI_CMD_ERR_EN
    chk("ill_err_sticky", err, 1);
`endif

    // Reset while a read word is waiting for the host
    clear_logs();
    rd_q.push_back(32'h99);
    out_stall = 100;
    send_hdr(32'd0, 64'h4000, 64'd0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!out_valid && t < 100);
    if (t >= 100) timeout_fail("rst_mid_wait");
    chk("rst_mid_out_bits", out_bits, 64'h99);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    out_stall = 0;
    @(posedge clock); #1;
    clear_logs();
    send_hdr(32'd1, 64'h5000, 64'd0);
    send(32'h66);
    wait_idle("rst_mid_idle");
    chk("rst_mid_nreq", 64'(log_addr.size()), 1);
    if (log_addr.size() == 1) chk_req("rst_mid_req", 0, 64'h5000, 32'h66, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
